// File: rtl/lsu_mem_master_pkg.sv
// Shared constants and types for the load/store memory master.
package lsu_mem_master_pkg;

    // Access-size encodings, identical to the data-memory model
    localparam logic [1:0] BYTE         = 2'b00;
    localparam logic [1:0] HALFWORD     = 2'b01;
    localparam logic [1:0] WORD         = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Read data returned with a faulting response
    localparam logic [31:0] BADADDR_FAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Number of bytes touched by an access of the given size
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            BYTE:     return 3'd1;
            HALFWORD: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus memory-side bus of the load/store unit.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_w_enable;
    logic [1:0]  mem_access_size;
    logic        mem_rd_un;
    logic [31:0] mem_data_out;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_rd_un
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_address, mem_data_in, mem_w_enable, mem_access_size, mem_rd_un
    );
endinterface

// File: rtl/lsu_mem_master_range_check.sv
// Combinational classification of a request: fault, misalignment, beat count.
module lsu_range_check
    import lsu_mem_master_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE      = 32'd1048576
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        o_fault,
    output logic        o_misaligned,
    output logic [2:0]  o_beats
);

    logic [32:0] w_last;
    logic [32:0] w_limit;

    // 33-bit arithmetic so an access running past 2^32 is caught, not wrapped
    always_comb begin
        o_beats = size_bytes(i_size);
        w_last  = {1'b0, i_addr} + {30'b0, o_beats} - 33'd1;
        w_limit = {1'b0, START_ADDRESS} + {1'b0, MEM_SIZE};
        o_fault = (i_size == SIZE_ILLEGAL) || (i_addr < START_ADDRESS) || (w_last >= w_limit);
        case (i_size)
            HALFWORD: o_misaligned = i_addr[0];
            WORD:     o_misaligned = (i_addr[1:0] != 2'b00);
            default:  o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: one request at a time, aligned accesses in a
// single beat, misaligned halfword/word accesses as sequential byte beats.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE      = 32'd1048576
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_master_if.master  bus
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;

    logic        r_we;
    logic        r_uns;
    logic        r_fault;
    logic [1:0]  r_size;
    logic [1:0]  r_beat;
    logic [1:0]  r_last_beat;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_addr_hold;
    logic [31:0] r_data_hold;

    logic        w_fault;
    logic        w_misaligned;
    logic        w_accept;
    logic [2:0]  w_beats;
    logic [2:0]  w_beats_m1;
    logic [31:0] w_beat_addr;
    logic [31:0] w_beat_data;
    logic [31:0] w_lanes;

    lsu_range_check #(
        .START_ADDRESS (START_ADDRESS),
        .MEM_SIZE      (MEM_SIZE)
    ) u_range_check (
        .i_addr       (bus.req_addr),
        .i_size       (bus.req_size),
        .o_fault      (w_fault),
        .o_misaligned (w_misaligned),
        .o_beats      (w_beats)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and bus outputs; reset forces every output low so an
    // interrupted split cannot write a further byte on the reset edge
    always_comb begin
        w_next               = r_state;
        w_accept             = 1'b0;
        w_beat_addr          = r_addr + {30'b0, r_beat};
        w_beat_data          = {24'b0, r_wdata[{r_beat, 3'b000} +: 8]};
        bus.req_ready        = 1'b0;
        bus.resp_valid       = 1'b0;
        bus.resp_rdata       = '0;
        bus.resp_fault       = 1'b0;
        bus.mem_address      = r_addr_hold;
        bus.mem_data_in      = r_data_hold;
        bus.mem_w_enable     = 1'b0;
        bus.mem_access_size  = WORD;
        bus.mem_rd_un        = 1'b0;
        if (reset) begin
            bus.mem_address     = '0;
            bus.mem_data_in     = '0;
            bus.mem_access_size = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        w_accept = 1'b1;
                        if (w_fault)           w_next = RESP;
                        else if (w_misaligned) w_next = SPLIT;
                        else                   w_next = ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_address     = r_addr;
                    bus.mem_access_size = r_size;
                    bus.mem_rd_un       = r_uns;
                    bus.mem_data_in     = r_wdata;
                    bus.mem_w_enable    = r_we;
                    w_next              = RESP;
                end
                SPLIT: begin
                    bus.mem_address     = w_beat_addr;
                    bus.mem_access_size = BYTE;
                    bus.mem_rd_un       = 1'b1;
                    bus.mem_data_in     = w_beat_data;
                    bus.mem_w_enable    = r_we;
                    if (r_beat == r_last_beat) w_next = RESP;
                end
                RESP: begin
                    bus.resp_valid = 1'b1;
                    bus.resp_rdata = r_fault ? BADADDR_FAULT : r_rdata;
                    bus.resp_fault = r_fault;
                    w_next         = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Split-load lane assembly; halfword extension is reapplied every beat and
    // is correct once lane 1 has arrived on the final beat
    always_comb begin
        w_beats_m1                   = w_beats - 3'd1;
        w_lanes                      = r_rdata;
        w_lanes[{r_beat, 3'b000} +: 8] = bus.mem_data_out[7:0];
        if (r_size == HALFWORD) w_lanes[31:16] = r_uns ? 16'h0000 : {16{w_lanes[15]}};
    end

    // Request capture, beat counting, load data and held bus values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_fault     <= 1'b0;
            r_size      <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            if (w_accept) begin
                r_we        <= bus.req_we;
                r_uns       <= bus.req_unsigned;
                r_fault     <= w_fault;
                r_size      <= bus.req_size;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_rdata     <= '0;
                r_beat      <= '0;
                r_last_beat <= w_beats_m1[1:0];
            end
            if (r_state == ACCESS || r_state == SPLIT) begin
                r_addr_hold <= bus.mem_address;
                r_data_hold <= bus.mem_data_in;
            end
            if (r_state == ACCESS && !r_we) r_rdata <= bus.mem_data_out;
            if (r_state == SPLIT) begin
                r_beat <= r_beat + 2'd1;
                if (!r_we) r_rdata <= w_lanes;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed, table-driven bench for lsu_mem_master with a byte-array memory model.
module tb_lsu_mem_master;
    import lsu_mem_master_pkg::*;

    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] MSIZE = 32'd1048576;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_master_if bus();

    lsu_mem_master #(
        .START_ADDRESS (START),
        .MEM_SIZE      (MSIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Byte-addressed data memory with combinational, self-extending reads
    logic [7:0]  mem [0:1048575];
    logic [31:0] m_off;
    logic [19:0] m_idx;
    logic [7:0]  m_b0, m_b1, m_b2, m_b3;

    always_comb begin
        m_off = bus.mem_address - START;
        m_idx = m_off[19:0];
        m_b0  = mem[m_idx];
        m_b1  = mem[m_idx + 20'd1];
        m_b2  = mem[m_idx + 20'd2];
        m_b3  = mem[m_idx + 20'd3];
        bus.mem_data_out = '0;
        if (m_off < MSIZE) begin
            case (bus.mem_access_size)
                BYTE:     bus.mem_data_out = bus.mem_rd_un ? {24'b0, m_b0} : {{24{m_b0[7]}}, m_b0};
                HALFWORD: bus.mem_data_out = bus.mem_rd_un ? {16'b0, m_b1, m_b0} : {{16{m_b1[7]}}, m_b1, m_b0};
                WORD:     bus.mem_data_out = {m_b3, m_b2, m_b1, m_b0};
                default:  bus.mem_data_out = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_w_enable && m_off < MSIZE) begin
            case (bus.mem_access_size)
                BYTE: mem[m_idx] <= bus.mem_data_in[7:0];
                HALFWORD: begin
                    mem[m_idx]         <= bus.mem_data_in[7:0];
                    mem[m_idx + 20'd1] <= bus.mem_data_in[15:8];
                end
                WORD: begin
                    mem[m_idx]         <= bus.mem_data_in[7:0];
                    mem[m_idx + 20'd1] <= bus.mem_data_in[15:8];
                    mem[m_idx + 20'd2] <= bus.mem_data_in[23:16];
                    mem[m_idx + 20'd3] <= bus.mem_data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        int          lat;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    int n_vec  = 0;
    int n_miss = 0;
    int n_we;

    logic [31:0] log_addr [0:12];
    logic [31:0] log_din  [0:12];
    logic [1:0]  log_size [0:12];
    logic        log_we   [0:12];
    logic        log_rdun [0:12];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input int lat,
                                input logic [31:0] rdata, input logic fault);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.lat = lat; v.rdata = rdata; v.fault = fault;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns,
                           output int lat, output logic [31:0] rdata, output logic fault);
        lat = -1; rdata = '0; fault = 1'b0; n_we = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_size = size; bus.req_unsigned = uns;
        check("ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            log_addr[n] = bus.mem_address;
            log_din[n]  = bus.mem_data_in;
            log_size[n] = bus.mem_access_size;
            log_we[n]   = bus.mem_w_enable;
            log_rdun[n] = bus.mem_rd_un;
            if (bus.mem_w_enable) n_we++;
            if (bus.resp_valid) begin
                lat = n; rdata = bus.resp_rdata; fault = bus.resp_fault;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        flt;
        logic [31:0] bb_addr [3];
        logic [31:0] bb_exp  [3];
        int          acc_cyc [3];
        int          rsp_cyc [3];
        int          idx, nresp;
        logic        seen_resp;

        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        for (int i = 1048560; i < 1048576; i++) mem[i] <= 8'h00;
        #1;
        mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44; mem[4] <= 8'h55;
        mem[20'hFFFFF] <= 8'h7F;

        vecs[0]  = mk(0, 32'h0100_0001, 0,            WORD,         0, 5, 32'h5544_3322, 0);
        vecs[1]  = mk(0, 32'h0100_0002, 0,            HALFWORD,     0, 2, 32'h0000_4433, 0);
        vecs[2]  = mk(0, 32'h0100_0003, 0,            BYTE,         0, 2, 32'h0000_0044, 0);
        vecs[3]  = mk(1, 32'h0100_0004, 32'h85,       BYTE,         0, 2, 32'h0,         0);
        vecs[4]  = mk(0, 32'h0100_0003, 0,            HALFWORD,     0, 3, 32'hFFFF_8544, 0);
        vecs[5]  = mk(0, 32'h0100_0003, 0,            HALFWORD,     1, 3, 32'h0000_8544, 0);
        vecs[6]  = mk(0, 32'h0100_0004, 0,            BYTE,         0, 2, 32'hFFFF_FF85, 0);
        vecs[7]  = mk(0, 32'h0100_0004, 0,            BYTE,         1, 2, 32'h0000_0085, 0);
        vecs[8]  = mk(1, 32'h0100_0004, 32'hDEADBEEF, WORD,         0, 2, 32'h0,         0);
        vecs[9]  = mk(0, 32'h0100_0004, 0,            WORD,         0, 2, 32'hDEAD_BEEF, 0);
        vecs[10] = mk(1, 32'h010F_FFFE, 32'h12345678, WORD,         0, 1, 32'h0,         1);
        vecs[11] = mk(0, 32'h0100_0000, 0,            SIZE_ILLEGAL, 0, 1, 32'h0,         1);
        vecs[12] = mk(0, 32'h00FF_FFFF, 0,            BYTE,         0, 1, 32'h0,         1);
        vecs[13] = mk(0, 32'h010F_FFFF, 0,            BYTE,         1, 2, 32'h0000_007F, 0);
        vecs[14] = mk(0, 32'h010F_FFFF, 0,            HALFWORD,     0, 1, 32'h0,         1);
        vecs[15] = mk(1, 32'h0100_0021, 32'h1234,     HALFWORD,     0, 3, 32'h0,         0);
        vecs[16] = mk(0, 32'h0100_0021, 0,            HALFWORD,     1, 3, 32'h0000_1234, 0);
        vecs[17] = mk(0, 32'h0100_0022, 0,            BYTE,         1, 2, 32'h0000_0012, 0);
        vecs[18] = mk(1, 32'h0100_0032, 32'hCAFEF00D, WORD,         0, 5, 32'h0,         0);
        vecs[19] = mk(0, 32'h0100_0030, 0,            WORD,         0, 2, 32'hF00D_0000, 0);
        vecs[20] = mk(0, 32'h0100_0032, 0,            WORD,         0, 5, 32'hCAFE_F00D, 0);
        vecs[21] = mk(0, 32'h0100_0034, 0,            HALFWORD,     0, 2, 32'hFFFF_CAFE, 0);
        vecs[22] = mk(0, 32'h0100_0034, 0,            HALFWORD,     1, 2, 32'h0000_CAFE, 0);
        vecs[23] = mk(0, 32'h010F_FFFC, 0,            WORD,         0, 2, 32'h7F00_0000, 0);
        vecs[24] = mk(0, 32'h010F_FFFD, 0,            WORD,         0, 1, 32'h0,         1);

        // Reset state
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_size = '0; bus.req_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  {31'b0, bus.req_ready},    32'd0);
        check("rst_resp_valid", {31'b0, bus.resp_valid},   32'd0);
        check("rst_w_enable",   {31'b0, bus.mem_w_enable}, 32'd0);
        check("rst_access_size", {30'b0, bus.mem_access_size}, 32'd0);
        check("rst_address",    bus.mem_address,           32'd0);
        reset = 1'b0;
        #1;
        check("idle_req_ready",  {31'b0, bus.req_ready},        32'd1);
        check("idle_access_size", {30'b0, bus.mem_access_size}, {30'b0, WORD});

        // Table of single requests
        for (int i = 0; i < NVEC; i++) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, lat, rd, flt);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_fault", i), {31'b0, flt}, {31'b0, vecs[i].fault});
        end

        // Aligned store: a single WORD beat one cycle after accept
        run_req(1'b1, 32'h0100_0040, 32'h0123_4567, WORD, 1'b0, lat, rd, flt);
        check("st_latency", lat, 2);
        check("st_beat_addr", log_addr[1], 32'h0100_0040);
        check("st_beat_size", {30'b0, log_size[1]}, {30'b0, WORD});
        check("st_beat_we", {31'b0, log_we[1]}, 32'd1);
        check("st_beat_data", log_din[1], 32'h0123_4567);

        // Misaligned word load: four byte beats, then held address with WORD size
        run_req(1'b0, 32'h0100_0001, '0, WORD, 1'b0, lat, rd, flt);
        check("mw_latency", lat, 5);
        check("mw_rdata", rd, 32'hEF44_3322);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mw_beat%0d_addr", k), log_addr[k+1], 32'h0100_0001 + k);
            check($sformatf("mw_beat%0d_size", k), {30'b0, log_size[k+1]}, {30'b0, BYTE});
            check($sformatf("mw_beat%0d_rdun", k), {31'b0, log_rdun[k+1]}, 32'd1);
        end
        check("mw_resp_size", {30'b0, log_size[5]}, {30'b0, WORD});
        check("mw_resp_addr_hold", log_addr[5], 32'h0100_0004);

        // Out-of-range store: no write enable, memory untouched
        run_req(1'b1, 32'h010F_FFFE, 32'hA5A5_A5A5, WORD, 1'b0, lat, rd, flt);
        check("oor_latency", lat, 1);
        check("oor_fault", {31'b0, flt}, 32'd1);
        check("oor_no_write", n_we, 0);
        check("oor_mem_fffe", {24'b0, mem[20'hFFFFE]}, 32'h00);
        check("oor_mem_ffff", {24'b0, mem[20'hFFFFF]}, 32'h7F);

        // Reset during beat 2 of a misaligned word store
        seen_resp = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h0100_0011;
        bus.req_wdata = 32'hAABB_CCDD; bus.req_size = WORD; bus.req_unsigned = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        seen_resp = seen_resp | bus.resp_valid;
        @(negedge clk);
        seen_resp = seen_resp | bus.resp_valid;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rmid_w_enable", {31'b0, bus.mem_w_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rmid_ready_after", {31'b0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            seen_resp = seen_resp | bus.resp_valid;
            @(negedge clk);
        end
        check("rmid_no_resp", {31'b0, seen_resp}, 32'd0);
        check("rmid_mem11", {24'b0, mem[20'h11]}, 32'hDD);
        check("rmid_mem12", {24'b0, mem[20'h12]}, 32'hCC);
        check("rmid_mem13", {24'b0, mem[20'h13]}, 32'h00);
        check("rmid_mem14", {24'b0, mem[20'h14]}, 32'h00);

        // Back-to-back aligned loads with req_valid held high
        bb_addr[0] = 32'h0100_0000; bb_exp[0] = 32'h4433_2211;
        bb_addr[1] = 32'h0100_0020; bb_exp[1] = 32'h0012_3400;
        bb_addr[2] = 32'h0100_0004; bb_exp[2] = 32'hDEAD_BEEF;
        idx = 0; nresp = 0;
        for (int k = 0; k < 3; k++) begin acc_cyc[k] = -100; rsp_cyc[k] = -100; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (nresp < 3) begin
                    rsp_cyc[nresp] = c;
                    check($sformatf("bb%0d_rdata", nresp), bus.resp_rdata, bb_exp[nresp]);
                end
                nresp++;
            end
            if (idx < 3) begin
                bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = bb_addr[idx];
                bus.req_size = WORD; bus.req_unsigned = 1'b0;
                if (bus.req_ready) begin
                    acc_cyc[idx] = c;
                    idx++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        check("bb_accept0", acc_cyc[0], 0);
        check("bb_accept1", acc_cyc[1], 3);
        check("bb_accept2", acc_cyc[2], 6);
        for (int k = 0; k < 3; k++) check($sformatf("bb%0d_resp_cycle", k), rsp_cyc[k], acc_cyc[k] + 2);
        check("bb_resp_count", nresp, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
